// File: rtl/mmu_ctrl.sv
// Job sequencer for the WIDTH x WIDTH systolic matrix unit: weight tile load,
// data streaming with stall freeze, skewed drain and result addressing.
module mmu_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ADDR_W  = 8,
    parameter int OUT_LAT = 2*WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        num_rows,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              wwrite,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic              active,
    output logic              d_rd_en,
    output logic [ADDR_W-1:0] d_rd_addr,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr
);

    typedef enum logic [1:0] {S_IDLE, S_WLOAD, S_EXEC, S_FIN} state_t;

    localparam logic [15:0] WL = 16'(WIDTH);
    localparam logic [15:0] OL = 16'(OUT_LAT);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  nr;
    logic [15:0] last;

    assign last = {8'd0, nr} + OL - 16'd1;

    // Outputs are registered from the current state and count, so every
    // phase appears on the pins one cycle after the state is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            nr          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wwrite      <= 1'b0;
            w_rd_en     <= 1'b0;
            w_rd_addr   <= '0;
            active      <= 1'b0;
            d_rd_en     <= 1'b0;
            d_rd_addr   <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
        end else begin
            wwrite    <= 1'b0;
            w_rd_en   <= 1'b0;
            active    <= 1'b0;
            d_rd_en   <= 1'b0;
            out_wr_en <= 1'b0;
            done      <= 1'b0;
            busy      <= (state != S_IDLE) || start;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nr          <= num_rows;
                        cnt         <= '0;
                        w_rd_addr   <= '0;
                        d_rd_addr   <= '0;
                        out_wr_addr <= '0;
                        state       <= S_WLOAD;
                    end
                end
                S_WLOAD: begin
                    // Bottom row goes in first; stall cannot break the chain.
                    wwrite    <= 1'b1;
                    w_rd_en   <= 1'b1;
                    w_rd_addr <= ADDR_W'(WL - 16'd1 - cnt);
                    if (cnt == WL - 16'd1) begin
                        cnt   <= '0;
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_EXEC: begin
                    if (cnt < {8'd0, nr}) begin
                        d_rd_addr <= ADDR_W'(cnt);
                        d_rd_en   <= !stall;
                    end
                    if (cnt >= OL) begin
                        out_wr_addr <= ADDR_W'(cnt - OL);
                        out_wr_en   <= !stall;
                    end
                    if (!stall) begin
                        active <= 1'b1;
                        if (cnt == last) begin
                            cnt   <= '0;
                            state <= S_FIN;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
